// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle
module div_unit (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_valid,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    output logic        o_rd_wren
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic        op_rem;
    logic [4:0]  rd;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [4:0]  count;
    logic        neg_quo;
    logic        neg_rem;
    logic        bypass;
    logic [31:0] bypass_result;

    logic        is_signed;
    logic        div_zero;
    logic        overflow;
    logic        special;
    logic [31:0] special_result;
    logic [31:0] mag_rs1;
    logic [31:0] mag_rs2;

    assign is_signed = ~i_op[0];
    assign div_zero  = (i_rs2_data == 32'd0);
    assign overflow  = is_signed && (i_rs1_data == 32'h8000_0000) && (i_rs2_data == 32'hFFFF_FFFF);
    assign special   = div_zero | overflow;
    assign mag_rs1   = (is_signed && i_rs1_data[31]) ? -i_rs1_data : i_rs1_data;
    assign mag_rs2   = (is_signed && i_rs2_data[31]) ? -i_rs2_data : i_rs2_data;

    always_comb begin
        special_result = 32'd0;
        if (div_zero) begin
            special_result = i_op[1] ? i_rs1_data : 32'hFFFF_FFFF;
        end else if (overflow) begin
            special_result = i_op[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // 33-bit partial remainder: previous remainder with the next dividend bit shifted in
    logic [32:0] shifted;
    logic        fits;

    assign shifted = {remainder, dividend[31]};
    assign fits    = (shifted >= {1'b0, divisor});

    logic [31:0] quo_fixed;
    logic [31:0] rem_fixed;
    logic [31:0] result;

    assign quo_fixed = neg_quo ? -quotient : quotient;
    assign rem_fixed = neg_rem ? -remainder : remainder;
    assign result    = bypass ? bypass_result : (op_rem ? rem_fixed : quo_fixed);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (i_flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (i_start) state_next = special ? DONE : CALC;
                CALC:    if (count == 5'd31) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy    = (state != IDLE);
        o_rd_wren = o_valid && (o_rd_addr != 5'd0);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            op_rem        <= 1'b0;
            rd            <= 5'd0;
            dividend      <= 32'd0;
            divisor       <= 32'd0;
            quotient      <= 32'd0;
            remainder     <= 32'd0;
            count         <= 5'd0;
            neg_quo       <= 1'b0;
            neg_rem       <= 1'b0;
            bypass        <= 1'b0;
            bypass_result <= 32'd0;
            o_valid       <= 1'b0;
            o_rd_addr     <= 5'd0;
            o_rd_data     <= 32'd0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start && !i_flush) begin
                        op_rem        <= i_op[1];
                        rd            <= i_rd_addr;
                        dividend      <= mag_rs1;
                        divisor       <= mag_rs2;
                        quotient      <= 32'd0;
                        remainder     <= 32'd0;
                        count         <= 5'd0;
                        neg_quo       <= is_signed && (i_rs1_data[31] ^ i_rs2_data[31]);
                        neg_rem       <= is_signed && i_rs1_data[31];
                        bypass        <= special;
                        bypass_result <= special_result;
                    end
                end
                CALC: begin
                    // a fitting shifted value is below 2*divisor, so the low 32 bits hold the difference
                    if (fits) begin
                        remainder <= shifted[31:0] - divisor;
                    end else begin
                        remainder <= shifted[31:0];
                    end
                    quotient <= {quotient[30:0], fits};
                    dividend <= {dividend[30:0], 1'b0};
                    count    <= count + 5'd1;
                end
                DONE: begin
                    if (!i_flush) begin
                        o_valid   <= 1'b1;
                        o_rd_addr <= rd;
                        o_rd_data <= result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - randomized self-checking bench for div_unit against a behavioural model
module tb_div_unit;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op    = 2'd0;
    logic [31:0] rs1   = 32'd0;
    logic [31:0] rs2   = 32'd0;
    logic [4:0]  rd    = 5'd0;
    logic        busy;
    logic        valid;
    logic        wren;
    logic [4:0]  rd_out;
    logic [31:0] data_out;

    div_unit dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_op       (op),
        .i_rs1_data (rs1),
        .i_rs2_data (rs2),
        .i_rd_addr  (rd),
        .i_flush    (flush),
        .o_busy     (busy),
        .o_valid    (valid),
        .o_rd_addr  (rd_out),
        .o_rd_data  (data_out),
        .o_rd_wren  (wren)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic [4:0]  addr;
    } exp_t;

    exp_t        expq[$];
    int          cyc      = 0;
    int          checks   = 0;
    int          errors   = 0;
    int          busy_lo  = 1;
    int          busy_hi  = 0;
    int          zero_cyc = 1;
    logic [31:0] last_data = 32'd0;
    logic [4:0]  last_addr = 5'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    function automatic logic is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V M semantics from plain arithmetic: truncating division, remainder takes dividend sign
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (o[0]) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
        return o[1] ? r : q;
    endfunction

    // compare process: every cycle after the first reset edge
    always @(negedge clk) begin : compare
        exp_t e;
        if (cyc >= 1) begin
            chk("busy", 32'(busy), 32'((cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0));
            if (cyc == zero_cyc) begin
                chk("reset_valid", 32'(valid), 32'd0);
                chk("reset_busy", 32'(busy), 32'd0);
                chk("reset_data", data_out, 32'd0);
                chk("reset_addr", 32'(rd_out), 32'd0);
                chk("reset_wren", 32'(wren), 32'd0);
            end
            if (valid === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid at cycle %0d: got data %h addr %0d expected no result", cyc, data_out, rd_out);
                end else begin
                    e = expq.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("rd_data", data_out, e.data);
                    chk("rd_addr", 32'(rd_out), 32'(e.addr));
                    chk("rd_wren", 32'(wren), 32'(e.addr != 5'd0));
                    last_data = e.data;
                    last_addr = e.addr;
                end
            end else begin
                chk("valid_low", 32'(valid), 32'd0);
                chk("hold_data", data_out, last_data);
                chk("hold_addr", 32'(rd_out), 32'(last_addr));
                chk("wren_low", 32'(wren), 32'd0);
                if (expq.size() > 0 && expq[0].cyc <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_valid at cycle %0d: got no result expected data %h", cyc, expq[0].data);
                    void'(expq.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
        exp_t e;
        e.cyc  = cyc + 1 + (is_special(o, a, b) ? 1 : 33);
        e.data = model(o, a, b);
        e.addr = r;
        expq.push_back(e);
        busy_lo = cyc + 1;
        busy_hi = e.cyc - 1;
        start = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        rd    = r;
        tick();
        start = 1'b0;
        op    = 2'($urandom);
        rs1   = $urandom;
        rs2   = $urandom;
        rd    = 5'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (expq.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout at cycle %0d: got %0d pending expected 0", cyc, expq.size());
            expq.delete();
        end
        tick();
        tick();
    endtask

    task automatic to_valid();
        int n = 0;
        while (expq.size() > 0 && cyc < expq[0].cyc && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (expq.size() == 0 || cyc != expq[0].cyc) begin
            errors++;
            $display("FAIL to_valid at cycle %0d: got no pending result expected one due now", cyc);
        end
    endtask

    logic [1:0]  t_op  [11] = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd2, 2'd3, 2'd1, 2'd1, 2'd2, 2'd0, 2'd2};
    logic [31:0] t_a   [11] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'hFFFF_FFF9,
                                32'hFFFF_FFFF, 32'd42, 32'd13, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] t_b   [11] = '{32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd2,
                                32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_exp [11] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd1,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd13, 32'h8000_0000, 32'd0};

    initial begin
        #1000000;
        $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  o;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            chk("model_pin", model(t_op[i], t_a[i], t_b[i]), t_exp[i]);
            issue(t_op[i], t_a[i], t_b[i], (i == 0) ? 5'd5 : 5'(i + 10));
            wait_drain();
        end

        issue(2'd1, 32'h1234_5678, 32'd3, 5'd4);
        repeat (9) tick();
        flush = 1'b1;
        expq.delete();
        busy_hi = cyc;
        tick();
        flush = 1'b0;
        repeat (40) tick();

        start = 1'b1;
        flush = 1'b1;
        op    = 2'd1;
        rs1   = 32'd50;
        rs2   = 32'd5;
        rd    = 5'd3;
        tick();
        start = 1'b0;
        flush = 1'b0;
        repeat (40) tick();

        issue(2'd1, 32'd1000, 32'd3, 5'd7);
        repeat (5) tick();
        start = 1'b1;
        op    = 2'd0;
        rs1   = 32'd55;
        rs2   = 32'd5;
        rd    = 5'd9;
        repeat (3) tick();
        start = 1'b0;
        wait_drain();

        issue(2'd1, 32'd100, 32'd7, 5'd5);
        to_valid();
        issue(2'd0, 32'hFFFF_FF9C, 32'd7, 5'd6);
        wait_drain();

        issue(2'd0, 32'hFFFF_0000, 32'd7, 5'd12);
        repeat (4) tick();
        reset = 1'b1;
        expq.delete();
        busy_hi  = cyc;
        zero_cyc = cyc + 1;
        tick();
        last_data = 32'd0;
        last_addr = 5'd0;
        reset = 1'b0;
        repeat (40) tick();

        issue(2'd1, 32'd99, 32'd10, 5'd0);
        wait_drain();

        for (int i = 0; i < 150; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = -($urandom_range(1, 15));
                4: a = $urandom_range(0, 100);
                default: ;
            endcase
            issue(o, a, b, 5'($urandom));
            if ($urandom_range(0, 1) == 1) to_valid();
            else wait_drain();
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
